// File: rtl/sw_test_pkg.sv
// Shared definitions for the switch self-test path (bounce generator and debouncer).
package sw_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BOUNCE = 2'd1,
      ST_SETTLE = 2'd2
   } bounce_state_e;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   // Whole clock cycles in a window of 'us' microseconds at 'freq' Hz.
   function automatic int unsigned cycles_from_us(input longint unsigned freq,
                                                  input longint unsigned us);
      longint unsigned cyc;
      cyc = (freq * us) / 64'd1_000_000;
      return cyc[31:0];
   endfunction

endpackage

// File: rtl/sw_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift); a zero seed is replaced by 1 so it never locks up.
module lfsr16 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] seed,
   output logic [15:0] value
);
   import sw_test_pkg::*;

   logic [15:0] seed_safe;

   assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) value <= seed_safe;
      else         value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
   end

endmodule

// File: rtl/sw_bounce_gen.sv
// Switch-bounce emulator: toggles sw_o pseudo-randomly, then holds the requested level.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready for a request; sw_o holds the last settled level
//   ST_BOUNCE | sw_o toggles with random hold lengths until bounce_cnt hits 0
//   ST_SETTLE | sw_o held at target until settle_cnt hits 0, then done pulse
module sw_bounce_gen #(
   parameter int unsigned ClkFreq    = 100_000_000,
   parameter int unsigned BounceTime = 2,
   parameter int unsigned SettleTime = 12,
   parameter int unsigned HoldBits   = 4,
   parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   input  logic level_i,
   output logic ready_o,
   output logic sw_o,
   output logic busy_o,
   output logic done_tick_o
);
   import sw_test_pkg::*;

   localparam int unsigned BounceMax = cycles_from_us(ClkFreq, BounceTime);
   localparam int unsigned SettleMax = cycles_from_us(ClkFreq, SettleTime);
   localparam int BW = $clog2(BounceMax + 1);
   localparam int SW = $clog2(SettleMax + 1);

   if (BounceMax < 1) begin : g_chk_bounce
      $error("sw_bounce_gen: BounceMax must be at least 1 cycle");
   end
   if (SettleMax < 1) begin : g_chk_settle
      $error("sw_bounce_gen: SettleMax must be at least 1 cycle");
   end
   if (HoldBits < 1 || HoldBits > 16) begin : g_chk_hold
      $error("sw_bounce_gen: HoldBits must be in 1..16");
   end

   bounce_state_e         state_q, state_d;
   logic                  sw_q, sw_d;
   logic                  target_q, target_d;
   logic                  done_q, done_d;
   logic [BW-1:0]         bounce_cnt_q, bounce_cnt_d;
   logic [SW-1:0]         settle_cnt_q, settle_cnt_d;
   logic [HoldBits-1:0]   hold_cnt_q, hold_cnt_d;
   logic [15:0]           lfsr;
   logic                  lfsr_unused;

   lfsr16 u_lfsr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .seed   (LfsrSeed),
      .value  (lfsr)
   );

   // Only the low HoldBits feed the hold counter.
   assign lfsr_unused = ^lfsr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         sw_q         <= 1'b0;
         target_q     <= 1'b0;
         done_q       <= 1'b0;
         bounce_cnt_q <= '0;
         settle_cnt_q <= '0;
         hold_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         sw_q         <= sw_d;
         target_q     <= target_d;
         done_q       <= done_d;
         bounce_cnt_q <= bounce_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sw_d         = sw_q;
      target_d     = target_q;
      done_d       = 1'b0;
      bounce_cnt_d = bounce_cnt_q;
      settle_cnt_d = settle_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               if (level_i != sw_q) begin
                  target_d     = level_i;
                  bounce_cnt_d = BW'(BounceMax - 1);
                  hold_cnt_d   = lfsr[HoldBits-1:0];
                  sw_d         = ~sw_q;
                  state_d      = ST_BOUNCE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_BOUNCE: begin
            if (bounce_cnt_q == '0) begin
               // Final edge of the window always lands on the target level.
               sw_d         = target_q;
               settle_cnt_d = SW'(SettleMax - 1);
               state_d      = ST_SETTLE;
            end else begin
               bounce_cnt_d = bounce_cnt_q - BW'(1);
               if (hold_cnt_q == '0) begin
                  sw_d       = ~sw_q;
                  hold_cnt_d = lfsr[HoldBits-1:0];
               end else begin
                  hold_cnt_d = hold_cnt_q - HoldBits'(1);
               end
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q - SW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready_o     = (state_q == ST_IDLE);
   assign busy_o      = (state_q == ST_BOUNCE) || (state_q == ST_SETTLE);
   assign sw_o        = sw_q;
   assign done_tick_o = done_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Randomized self-checking bench: two generators (seed ACE1 and seed 0) against a toggle-schedule model.
module tb_sw_bounce_gen;

   localparam int BM = 100_000_000 * 2 / 1_000_000;
   localparam int SM = 100_000_000 * 12 / 1_000_000;
   localparam int LAT = BM + SM + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req = 1'b0;
   logic level = 1'b0;

   logic a_ready, a_sw, a_busy, a_done;
   logic b_ready, b_sw, b_busy, b_done;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sw_bounce_gen dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .level_i(level),
      .ready_o(a_ready), .sw_o(a_sw), .busy_o(a_busy), .done_tick_o(a_done)
   );

   sw_bounce_gen #(.LfsrSeed(16'h0000)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .level_i(level),
      .ready_o(b_ready), .sw_o(b_sw), .busy_o(b_busy), .done_tick_o(b_done)
   );

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Model: per lane, absolute edge schedule since acceptance (edge k=0 is the accept edge).
   logic [15:0] seeds [2] = '{16'hACE1, 16'h0001};
   logic [15:0] m_lfsr [2] = '{16'hACE1, 16'h0001};
   logic        m_sw   [2] = '{1'b0, 1'b0};
   logic        m_busy [2] = '{1'b0, 1'b0};
   logic        m_done [2] = '{1'b0, 1'b0};
   logic        m_tgt  [2] = '{1'b0, 1'b0};
   int          m_k    [2] = '{0, 0};
   int          m_next [2] = '{0, 0};

   always @(posedge clk or negedge rst_n) begin : model
      logic [15:0] l;
      logic        sw, busy, done, tgt;
      int          k, nxt;
      for (int ln = 0; ln < 2; ln++) begin
         if (!rst_n) begin
            m_lfsr[ln] <= seeds[ln];
            m_sw[ln]   <= 1'b0;
            m_busy[ln] <= 1'b0;
            m_done[ln] <= 1'b0;
            m_tgt[ln]  <= 1'b0;
            m_k[ln]    <= 0;
            m_next[ln] <= 0;
         end else begin
            l = m_lfsr[ln]; sw = m_sw[ln]; busy = m_busy[ln]; tgt = m_tgt[ln];
            k = m_k[ln]; nxt = m_next[ln]; done = 1'b0;
            if (!busy) begin
               if (req) begin
                  if (level != sw) begin
                     busy = 1'b1; tgt = level; k = 0; sw = ~sw;
                     nxt = int'(l[3:0]) + 1;
                  end else begin
                     done = 1'b1;
                  end
               end
            end else begin
               k = k + 1;
               if (k < BM) begin
                  if (k == nxt) begin
                     sw = ~sw;
                     nxt = k + int'(l[3:0]) + 1;
                  end
               end else if (k == BM) begin
                  sw = tgt;
               end else if (k == BM + SM) begin
                  done = 1'b1; busy = 1'b0;
               end
            end
            m_lfsr[ln] <= lfsr_step(l);
            m_sw[ln] <= sw; m_busy[ln] <= busy; m_done[ln] <= done;
            m_tgt[ln] <= tgt; m_k[ln] <= k; m_next[ln] <= nxt;
         end
      end
   end

   always @(negedge clk) begin : compare
      check("a_sw",    {15'b0, a_sw},    {15'b0, m_sw[0]});
      check("a_ready", {15'b0, a_ready}, {15'b0, ~m_busy[0]});
      check("a_busy",  {15'b0, a_busy},  {15'b0, m_busy[0]});
      check("a_done",  {15'b0, a_done},  {15'b0, m_done[0]});
      check("a_lfsr",  dut_a.u_lfsr.value, m_lfsr[0]);
      check("b_sw",    {15'b0, b_sw},    {15'b0, m_sw[1]});
      check("b_ready", {15'b0, b_ready}, {15'b0, ~m_busy[1]});
      check("b_busy",  {15'b0, b_busy},  {15'b0, m_busy[1]});
      check("b_done",  {15'b0, b_done},  {15'b0, m_done[1]});
      check("b_lfsr",  dut_b.u_lfsr.value, m_lfsr[1]);
   end

   task automatic run_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic send(input logic lvl, output int t);
      @(negedge clk);
      req = 1'b1; level = lvl; t = cyc;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic pulse_req(input logic lvl);
      req = 1'b1; level = lvl;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_done(output int at, input int budget);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if (a_done) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      if (at < 0) check("done_timeout", 16'd0, 16'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rst_sw"},    {12'b0, a_sw, a_ready, a_busy, a_done}, 16'h0004);
      check({tag, "_rst_sw_b"},  {12'b0, b_sw, b_ready, b_busy, b_done}, 16'h0004);
   endtask

   initial begin
      int t, at, n_done;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("init");
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("lfsr_a_step1", dut_a.u_lfsr.value, 16'hE270);
      check("lfsr_b_step1", dut_b.u_lfsr.value, 16'hB400);
      @(negedge clk);
      check("lfsr_a_step2", dut_a.u_lfsr.value, 16'h7138);
      check("lfsr_b_step2", dut_b.u_lfsr.value, 16'h5A00);
      repeat (100) @(negedge clk);

      // Full 0->1 request with two ignored requests during the operation.
      send(1'b1, t);
      check("ready_low_t1", {15'b0, a_ready}, 16'd0);
      run_to(t + 50);
      pulse_req(1'b0);
      run_to(t + BM + 1);
      check("sw_settled_t201", {15'b0, a_sw}, 16'd1);
      run_to(t + 700);
      pulse_req(1'b0);
      wait_done(at, 1000);
      check("done_latency", 16'(at - t), 16'(LAT));
      check("ready_after_done", {15'b0, a_ready}, 16'd1);

      // Same-level request: immediate done, no bounce.
      repeat (5) @(negedge clk);
      send(1'b1, t);
      check("same_level_done", {14'b0, a_done, a_busy}, 16'h0002);

      // Reset in the middle of SETTLE.
      repeat (5) @(negedge clk);
      send(1'b0, t);
      run_to(t + 300);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < LAT + 100; i++) begin
         @(negedge clk);
         if (a_done || b_done) n_done++;
      end
      check("no_done_after_reset", 16'(n_done), 16'd0);

      // Randomized requests, occasionally with a stray request mid-operation.
      for (int it = 0; it < 12; it++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         send(1'($urandom_range(0, 1)), t);
         if (m_busy[0] && ($urandom_range(0, 1) == 1)) begin
            run_to(t + 1 + int'($urandom_range(1, 1390)));
            pulse_req(1'($urandom_range(0, 1)));
         end
         wait_done(at, LAT + 10);
         if (at - t > 1) check("rand_latency", 16'(at - t), 16'(LAT));
         else            check("rand_latency_short", 16'(at - t), 16'd1);
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
